// File: rtl/result_check_engine.sv
// Streams a result region against a golden region under a bit mask, counting matches and mismatches
// and recording the first failing offset. Also times a DUT run from its run/busy handshake.
module result_check_engine #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 13,
  parameter int CYC_WIDTH  = 24,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] res_base,
  input  logic [ADDR_WIDTH-1:0] gold_base,
  input  logic [CNT_WIDTH-1:0]  num_results,
  input  logic [DATA_WIDTH-1:0] cmp_mask,
  output logic [ADDR_WIDTH-1:0] res_read_address,
  input  logic [DATA_WIDTH-1:0] res_read_data,
  output logic [ADDR_WIDTH-1:0] gold_read_address,
  input  logic [DATA_WIDTH-1:0] gold_read_data,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic                  first_miss_valid,
  output logic [CNT_WIDTH-1:0]  first_miss_offset,
  input  logic                  dut_run,
  input  logic                  dut_busy,
  output logic [CYC_WIDTH-1:0]  cycle_count,
  output logic                  cycle_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {T_IDLE, T_ARM, T_RUN} tstate_t;

  state_t                state, state_nxt;
  tstate_t               tstate, tstate_nxt;
  logic [CNT_WIDTH-1:0]  num_lat, issue_idx, retire_idx;
  logic [DATA_WIDTH-1:0] mask_lat;
  logic [READ_LAT-1:0]   vld_p, vld_p_nxt;
  logic                  accept, issue, last_issue, retire, miss;

  function automatic logic [CNT_WIDTH-1:0] sat_cnt(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  function automatic logic [CYC_WIDTH-1:0] sat_cyc(input logic [CYC_WIDTH-1:0] v);
    return (&v) ? v : v + CYC_WIDTH'(1);
  endfunction

  assign accept     = start && (state == IDLE || state == DONE);
  assign issue      = (state == ISSUE);
  assign last_issue = issue && (issue_idx == num_lat - CNT_WIDTH'(1));
  assign vld_p_nxt  = READ_LAT'({vld_p, issue});
  assign retire     = vld_p[READ_LAT-1];
  assign miss       = |((res_read_data ^ gold_read_data) & mask_lat);
  assign busy       = (state == ISSUE) || (state == DRAIN);
  assign done       = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // An empty pass goes straight to DRAIN so it still shows one busy cycle before DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start)              state_nxt = (num_results == '0) ? DRAIN : ISSUE;
        else if (state == DONE) state_nxt = IDLE;
      end
      ISSUE:   if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (vld_p_nxt == '0) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p             <= '0;
      num_lat           <= '0;
      mask_lat          <= '0;
      issue_idx         <= '0;
      retire_idx        <= '0;
      res_read_address  <= '0;
      gold_read_address <= '0;
      match_count       <= '0;
      mismatch_count    <= '0;
      first_miss_valid  <= 1'b0;
      first_miss_offset <= '0;
    end else begin
      vld_p <= vld_p_nxt;
      if (accept) begin
        num_lat           <= num_results;
        mask_lat          <= cmp_mask;
        issue_idx         <= '0;
        retire_idx        <= '0;
        res_read_address  <= res_base;
        gold_read_address <= gold_base;
        match_count       <= '0;
        mismatch_count    <= '0;
        first_miss_valid  <= 1'b0;
        first_miss_offset <= '0;
      end else begin
        if (issue && !last_issue) begin
          issue_idx         <= issue_idx + CNT_WIDTH'(1);
          res_read_address  <= res_read_address + ADDR_WIDTH'(1);
          gold_read_address <= gold_read_address + ADDR_WIDTH'(1);
        end
        // Tagged data emerges here; retire_idx is the offset of the word being compared.
        if (retire) begin
          retire_idx <= retire_idx + CNT_WIDTH'(1);
          if (miss) begin
            mismatch_count <= sat_cnt(mismatch_count);
            if (!first_miss_valid) begin
              first_miss_valid  <= 1'b1;
              first_miss_offset <= retire_idx;
            end
          end else begin
            match_count <= sat_cnt(match_count);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tstate <= T_IDLE;
    else       tstate <= tstate_nxt;
  end

  always_comb begin
    tstate_nxt = tstate;
    case (tstate)
      T_IDLE:  if (dut_run && !dut_busy) tstate_nxt = T_ARM;
      T_ARM:   if (dut_busy) tstate_nxt = T_RUN;
      T_RUN:   if (!dut_busy) tstate_nxt = T_IDLE;
      default: tstate_nxt = T_IDLE;
    endcase
  end

  // The busy-fall cycle itself is counted, then the count freezes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
      cycle_valid <= 1'b0;
    end else if (tstate == T_IDLE) begin
      if (dut_run && !dut_busy) begin
        cycle_count <= '0;
        cycle_valid <= 1'b0;
      end
    end else begin
      cycle_count <= sat_cyc(cycle_count);
      if (tstate == T_RUN && !dut_busy) cycle_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_result_check_engine.sv
// Directed bench for result_check_engine: SRAM models with one-cycle read latency and
// hand-computed expectations for compare passes, wrap, empty pass, timer and mid-pass reset.
module tb_result_check_engine;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [11:0] res_base, gold_base, res_read_address, gold_read_address;
  logic [12:0] num_results, match_count, mismatch_count, first_miss_offset;
  logic [15:0] cmp_mask, res_read_data, gold_read_data;
  logic        busy, done, first_miss_valid, dut_run, dut_busy, cycle_valid;
  logic [23:0] cycle_count;

  logic [15:0] res_mem [4096];
  logic [15:0] gold_mem[4096];
  logic [11:0] ra_q[$], ga_q[$];
  int vectors = 0;
  int misses  = 0;

  result_check_engine dut (
    .clk(clk), .reset(reset), .start(start), .res_base(res_base), .gold_base(gold_base),
    .num_results(num_results), .cmp_mask(cmp_mask), .res_read_address(res_read_address),
    .res_read_data(res_read_data), .gold_read_address(gold_read_address),
    .gold_read_data(gold_read_data), .busy(busy), .done(done), .match_count(match_count),
    .mismatch_count(mismatch_count), .first_miss_valid(first_miss_valid),
    .first_miss_offset(first_miss_offset), .dut_run(dut_run), .dut_busy(dut_busy),
    .cycle_count(cycle_count), .cycle_valid(cycle_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    res_read_data  <= res_mem[res_read_address];
    gold_read_data <= gold_mem[gold_read_address];
  end

  // Pulses start, then waits for done; lat = cycles from start to done (-1 on timeout).
  task automatic do_pass(input logic [11:0] rb, input logic [11:0] gb, input logic [12:0] n,
                         input logic [15:0] m, output int lat);
    ra_q.delete();
    ga_q.delete();
    @(negedge clk);
    res_base = rb; gold_base = gb; num_results = n; cmp_mask = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20000) begin
      if (busy) begin
        ra_q.push_back(res_read_address);
        ga_q.push_back(gold_read_address);
      end
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dut_run = 1'b0; dut_busy = 1'b0;
    res_base = '0; gold_base = '0; num_results = '0; cmp_mask = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, first_miss_valid, cycle_valid} !== 4'b0000) begin
      misses++; $display("FAIL reset_flags got %b want 0000", {busy, done, first_miss_valid, cycle_valid});
    end
    vectors++;
    if ({match_count, mismatch_count, first_miss_offset} !== 39'd0) begin
      misses++; $display("FAIL reset_counts got %0d/%0d/%0d want 0/0/0", match_count, mismatch_count, first_miss_offset);
    end
    vectors++;
    if ({cycle_count, res_read_address, gold_read_address} !== 48'd0) begin
      misses++; $display("FAIL reset_cyc_addr got %0d %h %h want 0 000 000", cycle_count, res_read_address, gold_read_address);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_equal();
    int lat;
    for (int i = 0; i < 96; i++) begin
      res_mem[i] = 16'(i * 37 + 5);
      gold_mem[12'h400 + i] = 16'(i * 37 + 5);
    end
    do_pass(12'h000, 12'h400, 13'd96, 16'hFFFF, lat);
    vectors++;
    if (lat !== 98) begin misses++; $display("FAIL eq_latency got %0d want 98", lat); end
    vectors++;
    if (busy !== 1'b0) begin misses++; $display("FAIL eq_busy_at_done got %b want 0", busy); end
    vectors++;
    if ({match_count, mismatch_count, first_miss_valid} !== {13'd96, 13'd0, 1'b0}) begin
      misses++; $display("FAIL eq_counts got %0d/%0d/%b want 96/0/0", match_count, mismatch_count, first_miss_valid);
    end
    vectors++;
    if (ra_q.size() !== 97 || ra_q[0] !== 12'h000 || ra_q[95] !== 12'h05F || ga_q[95] !== 12'h45F) begin
      misses++; $display("FAIL eq_addr_seq got n=%0d %h %h %h want 97 000 05f 45f", ra_q.size(), ra_q[0], ra_q[95], ga_q[95]);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin misses++; $display("FAIL eq_done_width got %b want 0", done); end
  endtask

  task automatic test_single_error();
    int lat;
    for (int i = 0; i < 144; i++) begin
      res_mem[12'h100 + i]  = 16'(i) ^ 16'hA5A5;
      gold_mem[12'h600 + i] = 16'(i) ^ 16'hA5A5;
    end
    gold_mem[12'h600 + 37] = gold_mem[12'h600 + 37] ^ 16'h0008;
    do_pass(12'h100, 12'h600, 13'd144, 16'hFFFF, lat);
    vectors++;
    if (lat !== 146) begin misses++; $display("FAIL err_latency got %0d want 146", lat); end
    vectors++;
    if ({match_count, mismatch_count} !== {13'd143, 13'd1}) begin
      misses++; $display("FAIL err_counts got %0d/%0d want 143/1", match_count, mismatch_count);
    end
    vectors++;
    if ({first_miss_valid, first_miss_offset} !== {1'b1, 13'd37}) begin
      misses++; $display("FAIL err_first got %b/%0d want 1/37", first_miss_valid, first_miss_offset);
    end
  endtask

  task automatic test_mask();
    int lat;
    for (int i = 0; i < 20; i++) begin
      res_mem[12'h200 + i]  = 16'h1200 + 16'(i);
      gold_mem[12'h700 + i] = (16'h1200 + 16'(i)) ^ 16'(i + 1);
    end
    do_pass(12'h200, 12'h700, 13'd20, 16'hFF00, lat);
    vectors++;
    if ({match_count, mismatch_count, first_miss_valid} !== {13'd20, 13'd0, 1'b0}) begin
      misses++; $display("FAIL mask_hi got %0d/%0d/%b want 20/0/0", match_count, mismatch_count, first_miss_valid);
    end
    do_pass(12'h200, 12'h700, 13'd20, 16'hFFFF, lat);
    vectors++;
    if ({match_count, mismatch_count, first_miss_offset} !== {13'd0, 13'd20, 13'd0}) begin
      misses++; $display("FAIL mask_all got %0d/%0d/%0d want 0/20/0", match_count, mismatch_count, first_miss_offset);
    end
    // Differences are i+1; bit 1 is set for i = 1,2,5,6,9,10,13,14,17,18.
    do_pass(12'h200, 12'h700, 13'd20, 16'h0002, lat);
    vectors++;
    if ({match_count, mismatch_count, first_miss_offset} !== {13'd10, 13'd10, 13'd1}) begin
      misses++; $display("FAIL mask_bit1 got %0d/%0d/%0d want 10/10/1", match_count, mismatch_count, first_miss_offset);
    end
  endtask

  task automatic test_wrap();
    int lat;
    res_mem[12'hFFE] = 16'h1111; res_mem[12'hFFF] = 16'h2222;
    res_mem[12'h000] = 16'h3333; res_mem[12'h001] = 16'h4444;
    gold_mem[12'h810] = 16'h1111; gold_mem[12'h811] = 16'h2222;
    gold_mem[12'h812] = 16'h3330; gold_mem[12'h813] = 16'h4444;
    do_pass(12'hFFE, 12'h810, 13'd4, 16'hFFFF, lat);
    vectors++;
    if ({ra_q[0], ra_q[1], ra_q[2], ra_q[3]} !== 48'hFFE_FFF_000_001) begin
      misses++; $display("FAIL wrap_res_addr got %h %h %h %h want ffe fff 000 001", ra_q[0], ra_q[1], ra_q[2], ra_q[3]);
    end
    vectors++;
    if ({ga_q[0], ga_q[3]} !== 24'h810_813) begin
      misses++; $display("FAIL wrap_gold_addr got %h %h want 810 813", ga_q[0], ga_q[3]);
    end
    vectors++;
    if ({match_count, mismatch_count, first_miss_offset, lat} !== {13'd3, 13'd1, 13'd2, 32'd6}) begin
      misses++; $display("FAIL wrap_result got %0d/%0d/%0d lat %0d want 3/1/2 lat 6", match_count, mismatch_count, first_miss_offset, lat);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if ({res_read_address, gold_read_address} !== 24'h001_813) begin
      misses++; $display("FAIL wrap_addr_hold got %h %h want 001 813", res_read_address, gold_read_address);
    end
  endtask

  task automatic test_zero();
    int lat;
    do_pass(12'h300, 12'h900, 13'd0, 16'hFFFF, lat);
    vectors++;
    if (lat !== 2) begin misses++; $display("FAIL zero_latency got %0d want 2", lat); end
    vectors++;
    if ({match_count, mismatch_count, first_miss_valid} !== 27'd0) begin
      misses++; $display("FAIL zero_counts got %0d/%0d/%b want 0/0/0", match_count, mismatch_count, first_miss_valid);
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    @(negedge clk);
    res_base = 12'h200; gold_base = 12'h700; num_results = 13'd20; cmp_mask = 16'hFF00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    repeat (4) begin @(negedge clk); lat++; end
    num_results = 13'd5; cmp_mask = 16'hFFFF; res_base = 12'h000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat++;
    while (!done && lat < 20000) begin @(negedge clk); lat++; end
    vectors++;
    if ({match_count, mismatch_count, lat} !== {13'd20, 13'd0, 32'd22}) begin
      misses++; $display("FAIL busy_start got %0d/%0d lat %0d want 20/0 lat 22", match_count, mismatch_count, lat);
    end
  endtask

  task automatic test_timer();
    int last;
    for (int r = 0; r < 2; r++) begin
      last = (r == 0) ? 501 : 4;
      @(negedge clk);
      dut_run = 1'b1; dut_busy = 1'b0;
      for (int k = 1; k <= last + 1; k++) begin
        @(negedge clk);
        dut_run  = 1'b0;
        dut_busy = (k >= 2 && k <= last);
        if (k == 3) begin
          vectors++;
          if (cycle_valid !== 1'b0) begin misses++; $display("FAIL timer_mid_valid run %0d got %b want 0", r, cycle_valid); end
        end
      end
      @(negedge clk);
      dut_busy = 1'b0;
      vectors++;
      if ({cycle_valid, cycle_count} !== {1'b1, 24'(last + 1)}) begin
        misses++; $display("FAIL timer_count run %0d got %b/%0d want 1/%0d", r, cycle_valid, cycle_count, last + 1);
      end
      repeat (5) @(negedge clk);
      vectors++;
      if (cycle_count !== 24'(last + 1)) begin
        misses++; $display("FAIL timer_freeze run %0d got %0d want %0d", r, cycle_count, last + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int dones = 0;
    @(negedge clk);
    res_base = 12'h200; gold_base = 12'h700; num_results = 13'd96; cmp_mask = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if ({busy, done, first_miss_valid} !== 3'b000 || {match_count, mismatch_count} !== 26'd0) begin
      misses++; $display("FAIL rst_mid_clear got %b%b%b %0d/%0d want 000 0/0", busy, done, first_miss_valid, match_count, mismatch_count);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (100) begin @(negedge clk); if (done) dones++; end
    vectors++;
    if (dones !== 0) begin misses++; $display("FAIL rst_mid_no_done got %0d want 0", dones); end
    for (int i = 0; i < 96; i++) begin
      res_mem[12'h200 + i]  = 16'hC000 + 16'(i);
      gold_mem[12'h700 + i] = 16'hC000 + 16'(i);
    end
    do_pass(12'h200, 12'h700, 13'd96, 16'hFFFF, lat);
    vectors++;
    if ({match_count, mismatch_count, first_miss_valid, lat} !== {13'd96, 13'd0, 1'b0, 32'd98}) begin
      misses++; $display("FAIL rst_mid_rerun got %0d/%0d/%b lat %0d want 96/0/0 lat 98", match_count, mismatch_count, first_miss_valid, lat);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      res_mem[i]  = '0;
      gold_mem[i] = '0;
    end
    test_reset();
    test_all_equal();
    test_single_error();
    test_mask();
    test_wrap();
    test_zero();
    test_start_while_busy();
    test_timer();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
